// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command sequencer:
// opcodes, widths, sequencer states and the packed command word.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 4;
  localparam int RES_W  = 9;

  localparam logic [OP_W-1:0] OP_ADD       = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB       = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL       = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV       = 4'd3;
  localparam logic [OP_W-1:0] OP_LOG       = 4'd4;
  localparam logic [OP_W-1:0] OP_NOP       = 4'hF;
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command, ALU-side and response signals of the ALU command sequencer.
// master = the surrounding system, slave = the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int RW    = alu_pkg::RES_W
) ();

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [3:0]                 cmd_opcode;
  logic [3:0]                 cmd_a;
  logic [3:0]                 cmd_b;
  logic [3:0]                 alu_opcode;
  logic [3:0]                 alu_a;
  logic [3:0]                 alu_b;
  logic [RW-1:0]              alu_out;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [RW-1:0]              rsp_data;
  logic [3:0]                 rsp_opcode;
  logic                       rsp_illegal;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_out, rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b,
    input  rsp_valid, rsp_data, rsp_opcode, rsp_illegal, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_out, rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b,
    output rsp_valid, rsp_data, rsp_opcode, rsp_illegal, fifo_count
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH x 12-bit synchronous command FIFO with first-word-fall-through read.
// Push is ignored when full and pop when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  cmd_t                       wdata,
  input  logic                       pop,
  output cmd_t                       rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  // Power-of-two DEPTH lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count/pointers guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued {opcode, a, b} commands one at a time to the ALU's registered inputs,
// waits out its latency and presents the captured result on a valid/ready response port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int RW      = RES_W
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);

  localparam int         CW      = $clog2(DEPTH+1);
  localparam logic [2:0] LAT     = 3'(ALU_LAT);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]    state;
  logic [2:0]    wait_cnt;
  cmd_t          in_cmd;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          rsp_fire;
  logic          head_legal;

  logic [3:0]    alu_opcode_q;
  logic [3:0]    alu_a_q;
  logic [3:0]    alu_b_q;
  logic          rsp_valid_q;
  logic [RW-1:0] rsp_data_q;
  logic [3:0]    rsp_opcode_q;
  logic          rsp_illegal_q;

  assign in_cmd     = {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
  assign push       = bus.cmd_valid && !full;
  assign rsp_fire   = (state == S_HOLD) && rsp_valid_q && bus.rsp_ready;
  assign head_legal = op_is_legal(head.opcode);

  // A new command is taken from idle, or straight after a response handshake.
  always_comb begin
    // NOTE: default first so no path leaves pop unassigned and infers a latch.
    pop = 1'b0;
    if (!empty && (state == S_IDLE || rsp_fire)) pop = 1'b1;
  end

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      alu_opcode_q  <= OP_NOP;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_opcode_q  <= '0;
      rsp_illegal_q <= 1'b0;
    end else if (pop) begin
      if (head_legal) begin
        alu_opcode_q <= head.opcode;
        alu_a_q      <= head.a;
        alu_b_q      <= head.b;
        rsp_valid_q  <= 1'b0;
        state        <= S_ISSUE;
      end else begin
        // Illegal opcodes never reach the ALU; answered directly with a zero result.
        rsp_data_q    <= '0;
        rsp_opcode_q  <= head.opcode;
        rsp_illegal_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        state         <= S_HOLD;
      end
    end else begin
      case (state)
        S_ISSUE: begin
          wait_cnt <= LAT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 3'd1) begin
            rsp_data_q    <= bus.alu_out;
            rsp_opcode_q  <= alu_opcode_q;
            rsp_illegal_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            alu_opcode_q  <= OP_NOP;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            state         <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_HOLD: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.fifo_count  = count;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_opcode  = rsp_opcode_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-edge-latency stub ALU,
// a response monitor and an ALU-issue monitor.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int RW      = 9;

  typedef struct packed {
    logic [3:0] op;
    logic       ill;
    logic [8:0] data;
  } rsp_rec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   issue_cnt;
  int   bad_issue;
  logic [3:0] prev_alu_op;
  rsp_rec_t   rsp_q[$];

  alu_cmd_sequencer_if #(.DEPTH(DEPTH), .RW(RW)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_ADD:  return 9'(a) + 9'(b);
      OP_SUB:  return 9'(a) - 9'(b);
      OP_MUL:  return 9'(a) * 9'(b);
      OP_DIV:  return (b == 4'd0) ? 9'd0 : 9'(a / b);
      OP_LOG:  return 9'(a & b);
      default: return 9'd0;
    endcase
  endfunction

  // Stub ALU: result valid one edge after its inputs are registered.
  always @(posedge clk) bus.alu_out <= alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);

  initial prev_alu_op = 4'hF;
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back('{op: bus.rsp_opcode, ill: bus.rsp_illegal, data: bus.rsp_data});
    if (bus.alu_opcode != OP_NOP && prev_alu_op == OP_NOP) issue_cnt++;
    if (bus.alu_opcode > OP_MAX_LEGAL && bus.alu_opcode != OP_NOP) bad_issue++;
    prev_alu_op = bus.alu_opcode;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready) begin
        tick();
        bus.cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("FAIL send_cmd_timeout op=%0d got no cmd_ready within 50 cycles", op);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    for (int i = 0; i < 200; i++) begin
      if (rsp_q.size() >= n) break;
      tick();
    end
    ok = (rsp_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0d exp=0", bus.rsp_valid); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%0d exp=1", bus.cmd_ready); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.alu_opcode !== 4'hF) begin errors++; $display("FAIL reset_alu_opcode got=%0h exp=f", bus.alu_opcode); end
    checks++; if (bus.alu_a !== 4'd0 || bus.alu_b !== 4'd0) begin errors++; $display("FAIL reset_alu_ab got=%0h/%0h exp=0/0", bus.alu_a, bus.alu_b); end
    checks++; if (bus.rsp_data !== 9'd0 || bus.rsp_opcode !== 4'd0 || bus.rsp_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_fields got=%0d/%0d/%0d exp=0/0/0", bus.rsp_data, bus.rsp_opcode, bus.rsp_illegal);
    end
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    send_cmd(OP_ADD, 4'd3, 4'd5);  // accepted at edge E; now E+#1
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_E got=%0d exp=1", bus.fifo_count); end
    checks++; if (bus.alu_opcode !== 4'hF) begin errors++; $display("FAIL single_alu_idle_E got=%0h exp=f", bus.alu_opcode); end
    tick();  // E+1
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 12'h035) begin errors++; $display("FAIL single_issue_E1 got=%03h exp=035", {bus.alu_opcode, bus.alu_a, bus.alu_b}); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_E1 got=%0d exp=0", bus.fifo_count); end
    tick();  // E+2
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 12'h035) begin errors++; $display("FAIL single_hold_E2 got=%03h exp=035", {bus.alu_opcode, bus.alu_a, bus.alu_b}); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0d exp=0", bus.rsp_valid); end
    tick();  // E+3
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_E3 got=%0d exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 9'd8 || bus.rsp_opcode !== 4'd0 || bus.rsp_illegal !== 1'b0) begin
      errors++; $display("FAIL single_rsp got=%0d/%0d/%0d exp=8/0/0", bus.rsp_data, bus.rsp_opcode, bus.rsp_illegal);
    end
    checks++; if (bus.alu_opcode !== 4'hF) begin errors++; $display("FAIL single_alu_nop_E3 got=%0h exp=f", bus.alu_opcode); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear got=%0d exp=0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd10, 4'd1};
    logic [3:0] bv [6] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd12, 4'd1};
    int exp_sum [6] = '{3, 7, 11, 15, 22, 2};
    bit accepted = 1'b0;
    int hs_before = -1;
    bit ok;
    bus.rsp_ready = 1'b0;
    rsp_q.delete();
    for (int i = 0; i < 5; i++) send_cmd(OP_ADD, av[i], bv[i]);
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count got=%0d exp=4", bus.fifo_count); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%0d exp=0", bus.cmd_ready); end
    bus.cmd_opcode = OP_ADD; bus.cmd_a = av[5]; bus.cmd_b = bv[5]; bus.cmd_valid = 1'b1;
    tick(); tick();
    checks++; if (bus.fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_stall got=count %0d ready %0d exp=count 4 ready 0", bus.fifo_count, bus.cmd_ready);
    end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 9'd3) begin
      errors++; $display("FAIL b2b_first_held got=%0d/%0d exp=1/3", bus.rsp_valid, bus.rsp_data);
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        hs_before = rsp_q.size();
        accepted = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++; if (!accepted) begin errors++; $display("FAIL b2b_sixth_accept got=stalled exp=accepted"); end
    checks++; if (hs_before !== 1) begin errors++; $display("FAIL b2b_sixth_after_hs got=%0d exp=1", hs_before); end
    wait_rsp(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_rsp_timeout got=%0d exp=6", rsp_q.size()); end
    for (int i = 0; i < 6 && i < rsp_q.size(); i++) begin
      checks++; if (rsp_q[i].data !== 9'(exp_sum[i]) || rsp_q[i].op !== OP_ADD || rsp_q[i].ill !== 1'b0) begin
        errors++; $display("FAIL b2b_rsp%0d got=%0d/%0d/%0d exp=%0d/0/0", i, rsp_q[i].data, rsp_q[i].op, rsp_q[i].ill, exp_sum[i]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_illegal();
    int base;
    bit ok;
    bus.rsp_ready = 1'b1;
    rsp_q.delete();
    base = issue_cnt;
    send_cmd(OP_ADD, 4'd2, 4'd3);
    send_cmd(4'b1001, 4'd1, 4'd1);
    send_cmd(OP_ADD, 4'd4, 4'd4);
    wait_rsp(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal_rsp_timeout got=%0d exp=3", rsp_q.size()); end
    if (ok) begin
      checks++; if (rsp_q[0] !== rsp_rec_t'{op: 4'd0, ill: 1'b0, data: 9'd5}) begin
        errors++; $display("FAIL illegal_first_add got=%0d/%0d/%0d exp=0/0/5", rsp_q[0].op, rsp_q[0].ill, rsp_q[0].data);
      end
      checks++; if (rsp_q[1] !== rsp_rec_t'{op: 4'd9, ill: 1'b1, data: 9'd0}) begin
        errors++; $display("FAIL illegal_rsp got=%0d/%0d/%0d exp=9/1/0", rsp_q[1].op, rsp_q[1].ill, rsp_q[1].data);
      end
      checks++; if (rsp_q[2] !== rsp_rec_t'{op: 4'd0, ill: 1'b0, data: 9'd8}) begin
        errors++; $display("FAIL illegal_second_add got=%0d/%0d/%0d exp=0/0/8", rsp_q[2].op, rsp_q[2].ill, rsp_q[2].data);
      end
    end
    tick(); tick();
    checks++; if (issue_cnt - base !== 2) begin errors++; $display("FAIL illegal_issue_count got=%0d exp=2", issue_cnt - base); end
    checks++; if (bad_issue !== 0) begin errors++; $display("FAIL illegal_reached_alu got=%0d exp=0", bad_issue); end
  endtask

  task automatic test_ready_toggle();
    bit seen;
    bus.rsp_ready = 1'b0;
    rsp_q.delete();
    for (int i = 0; i < 3; i++) send_cmd(OP_MUL, 4'd15, 4'd15);
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.rsp_valid) begin seen = 1'b1; break; end
        tick();
      end
      checks++; if (!seen) begin errors++; $display("FAIL toggle_wait%0d got=no rsp_valid exp=rsp_valid", k); end
      for (int h = 0; h < 2; h++) begin
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 9'd225 || bus.rsp_opcode !== OP_MUL) begin
          errors++; $display("FAIL toggle_hold%0d_%0d got=%0d/%0d/%0d exp=1/225/2", k, h, bus.rsp_valid, bus.rsp_data, bus.rsp_opcode);
        end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (rsp_q.size() !== 3) begin errors++; $display("FAIL toggle_rsp_count got=%0d exp=3", rsp_q.size()); end
    for (int i = 0; i < rsp_q.size(); i++) begin
      checks++; if (rsp_q[i] !== rsp_rec_t'{op: OP_MUL, ill: 1'b0, data: 9'd225}) begin
        errors++; $display("FAIL toggle_rsp%0d got=%0d/%0d/%0d exp=2/0/225", i, rsp_q[i].op, rsp_q[i].ill, rsp_q[i].data);
      end
    end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL toggle_duplicate got=%0d exp=0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send_cmd(OP_ADD, 4'(i), 4'(i));
    // First command is now in WAIT, two entries still queued.
    checks++; if (bus.fifo_count !== 3'd2 || bus.alu_opcode !== OP_ADD || bus.alu_a !== 4'd1) begin
      errors++; $display("FAIL mid_pre_reset got=count %0d op %0h a %0d exp=count 2 op 0 a 1", bus.fifo_count, bus.alu_opcode, bus.alu_a);
    end
    rst = 1'b1;
    tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_fifo_flush got=count %0d ready %0d exp=count 0 ready 1", bus.fifo_count, bus.cmd_ready);
    end
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 12'hF00) begin
      errors++; $display("FAIL mid_alu_reset got=%03h exp=f00", {bus.alu_opcode, bus.alu_a, bus.alu_b});
    end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 9'd0 || bus.rsp_opcode !== 4'd0 || bus.rsp_illegal !== 1'b0) begin
      errors++; $display("FAIL mid_rsp_reset got=%0d/%0d/%0d/%0d exp=0/0/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_opcode, bus.rsp_illegal);
    end
    rst = 1'b0;
    rsp_q.delete();
    bus.rsp_ready = 1'b1;
    send_cmd(OP_DIV, 4'd13, 4'd4);
    wait_rsp(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_new_timeout got=%0d exp=1", rsp_q.size()); end
    if (ok) begin
      checks++; if (rsp_q[0] !== rsp_rec_t'{op: OP_DIV, ill: 1'b0, data: 9'd3}) begin
        errors++; $display("FAIL mid_new_rsp got=%0d/%0d/%0d exp=3/0/3", rsp_q[0].op, rsp_q[0].ill, rsp_q[0].data);
      end
    end
    for (int i = 0; i < 8; i++) tick();
    checks++; if (rsp_q.size() !== 1) begin errors++; $display("FAIL mid_stale_rsp got=%0d exp=1", rsp_q.size()); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    issue_cnt = 0;
    bad_issue = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_ready_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
